mem_loader: RTL and testbench
=============================

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1, rst input 1; all state changes on rising clk.
REQ-002 start  input  1  begin a load session; sampled only in IDLE.
REQ-003 abort  input  1  cancel any session; return to IDLE.
REQ-004 d_words  input  9  data words to load; latched at start.
REQ-005 i_words  input  9  instruction words to load; latched at start.
REQ-006 ld_valid  input  1  source word valid.
REQ-007 ld_data  input  32  source word.
REQ-008 ld_ready  output  1  loader accepts word; beat = ld_valid & ld_ready.
REQ-009 d_w_addr, d_w_dat, d_w_enb  output  10/32/1  data BRAM write port.
REQ-010 i_w_addr, i_w_dat, i_w_enb  output  10/32/1  instruction BRAM write port.
REQ-011 d_bram_init_done  output  1  data BRAM write port handed to core.
REQ-012 pc_stall  output  1  holds PC.
REQ-013 i_r_enb  output  1  instruction BRAM read enable.
REQ-014 rd_enbl  output  1  register file read enable.
REQ-015 core_rst  output  1  reset to PC/regfile/control.
REQ-016 busy, done, error  output  1 each  status.

Function
REQ-017 States SHALL be IDLE, LOAD_D, LOAD_I, FLUSH, RUN, ERROR.
REQ-018 IDLE & start: both counts ≤ 256 -> LOAD_D if d_words>0, else LOAD_I if i_words>0, else FLUSH; any count >256 -> ERROR.
REQ-019 ld_ready SHALL be 1 only in LOAD_D and LOAD_I, registered-free (decoded from state).
REQ-020 Each beat at edge N SHALL produce exactly one write: w_enb=1 during the cycle after N, addr = word_index*4 (byte address, 10 bits), dat = ld_data captured at N; w_enb=0 otherwise.
REQ-021 Word index SHALL start at 0 per memory and increment by 1 per beat; no wrap (max index 255, addr 0x3FC).
REQ-022 Accepting beat number d_words in LOAD_D -> LOAD_I if i_words>0, else FLUSH; beat number i_words in LOAD_I -> FLUSH.
REQ-023 ld_valid=0 SHALL stall with no write and no count change; no timeout.
REQ-024 FLUSH SHALL last exactly one cycle (final write completes there), then RUN.
REQ-025 In RUN: pc_stall=0, i_r_enb=1, rd_enbl=1, d_bram_init_done=1, core_rst=0, done=1; all other states: pc_stall=1, i_r_enb=0, rd_enbl=0, d_bram_init_done=0, core_rst=1, done=0.
REQ-026 busy=1 in LOAD_D, LOAD_I, FLUSH; error=1 only in ERROR.
REQ-027 RUN and ERROR SHALL be left only by abort or rst; start ignored outside IDLE.
REQ-028 abort SHALL take priority over start and beats: next state IDLE, a beat in the same cycle is not accepted, pending write (from previous beat) still completes.
REQ-029 d_w_enb and i_w_enb SHALL never be 1 in the same cycle except the single LOAD_D->LOAD_I boundary cycle.

Reset
REQ-030 rst SHALL force IDLE, counters/indices 0, all write enables/addresses/data 0, ld_ready=0, pc_stall=1, core_rst=1, i_r_enb=rd_enbl=d_bram_init_done=0, busy=done=error=0, including mid-load (pending write dropped).

Verification
REQ-031 start, d_words=3, i_words=7, ld_valid held 1 -> d writes at 0x0,0x4,0x8 then i writes 0x0..0x18, FLUSH, RUN at cycle 12 after start; done=1, pc_stall=0.
REQ-032 d_words=0, i_words=2 -> no d_w_enb pulse; i writes 0x0,0x4; RUN.
REQ-033 ld_valid toggled 1,0,1,0 during LOAD_I -> one write per accepted beat only, addresses contiguous.
REQ-034 start with i_words=257 -> ERROR, error=1, ld_ready=0, no writes; abort -> IDLE.
REQ-035 rst after 2 of 3 data beats -> all outputs at reset values next cycle; new start reloads from address 0x0.
REQ-036 abort asserted with ld_valid=1 in LOAD_D -> beat not accepted, IDLE next cycle, core_rst remains 1.

Source files
------------

// File: rtl/mem_loader_if.sv
// Loader-side bundle: load command, source word stream, both BRAM write
// ports and the core hand-off / status lines.
interface mem_loader_if;
  logic        start;
  logic        abort;
  logic [8:0]  d_words;
  logic [8:0]  i_words;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic        d_bram_init_done;
  logic        pc_stall;
  logic        i_r_enb;
  logic        rd_enbl;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  // Loader side
  modport slave (
    input  start, abort, d_words, i_words, ld_valid, ld_data,
    output ld_ready,
    output d_w_addr, d_w_dat, d_w_enb,
    output i_w_addr, i_w_dat, i_w_enb,
    output d_bram_init_done, pc_stall, i_r_enb, rd_enbl, core_rst,
    output busy, done, error
  );

  // Controller / source side
  modport master (
    output start, abort, d_words, i_words, ld_valid, ld_data,
    input  ld_ready,
    input  d_w_addr, d_w_dat, d_w_enb,
    input  i_w_addr, i_w_dat, i_w_enb,
    input  d_bram_init_done, pc_stall, i_r_enb, rd_enbl, core_rst,
    input  busy, done, error
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: streams d_words data words then i_words instruction words
// into the two BRAMs, then releases the core (RUN). Each accepted beat
// produces exactly one registered write in the following cycle.
module mem_loader (
  input  logic          clk,
  input  logic          rst,
  mem_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_D,
    LOAD_I,
    FLUSH,
    RUN,
    ERROR
  } state_t;

  state_t      state_q, state_d;

  logic [8:0]  d_len_q, i_len_q;
  logic [8:0]  d_idx_q, i_idx_q;

  logic        d_we_q, i_we_q;
  logic [9:0]  d_addr_q, i_addr_q;
  logic [31:0] d_dat_q, i_dat_q;

  logic        ready;
  logic        beat_d, beat_i;
  logic        d_last, i_last;
  logic        start_ok;
  logic        len_bad;

  // Handshake decode: ready comes straight from state; abort blocks any beat.
  always_comb begin
    ready    = (state_q == LOAD_D) || (state_q == LOAD_I);
    beat_d   = (state_q == LOAD_D) && bus.ld_valid && !bus.abort;
    beat_i   = (state_q == LOAD_I) && bus.ld_valid && !bus.abort;
    d_last   = (d_idx_q + 9'd1) == d_len_q;
    i_last   = (i_idx_q + 9'd1) == i_len_q;
    start_ok = (state_q == IDLE) && bus.start && !bus.abort;
    len_bad  = (bus.d_words > 9'd256) || (bus.i_words > 9'd256);
  end

  // Next-state logic; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (len_bad)                   state_d = ERROR;
            else if (bus.d_words != 9'd0)  state_d = LOAD_D;
            else if (bus.i_words != 9'd0)  state_d = LOAD_I;
            else                           state_d = FLUSH;
          end
        end
        LOAD_D: begin
          if (beat_d && d_last)
            state_d = (i_len_q != 9'd0) ? LOAD_I : FLUSH;
        end
        LOAD_I: begin
          if (beat_i && i_last)
            state_d = FLUSH;
        end
        FLUSH:   state_d = RUN;
        RUN:     state_d = RUN;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Session lengths, word indices and the registered write ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_len_q  <= '0;
      i_len_q  <= '0;
      d_idx_q  <= '0;
      i_idx_q  <= '0;
      d_we_q   <= 1'b0;
      i_we_q   <= 1'b0;
      d_addr_q <= '0;
      i_addr_q <= '0;
      d_dat_q  <= '0;
      i_dat_q  <= '0;
    end else begin
      d_we_q <= beat_d;
      i_we_q <= beat_i;
      if (start_ok) begin
        d_len_q <= bus.d_words;
        i_len_q <= bus.i_words;
        d_idx_q <= '0;
        i_idx_q <= '0;
      end
      if (beat_d) begin
        d_addr_q <= {d_idx_q[7:0], 2'b00};
        d_dat_q  <= bus.ld_data;
        d_idx_q  <= d_idx_q + 9'd1;
      end
      if (beat_i) begin
        i_addr_q <= {i_idx_q[7:0], 2'b00};
        i_dat_q  <= bus.ld_data;
        i_idx_q  <= i_idx_q + 9'd1;
      end
    end
  end

  // Output decode: the core is held in reset until RUN.
  always_comb begin
    bus.ld_ready         = ready;
    bus.d_w_enb          = d_we_q;
    bus.d_w_addr         = d_addr_q;
    bus.d_w_dat          = d_dat_q;
    bus.i_w_enb          = i_we_q;
    bus.i_w_addr         = i_addr_q;
    bus.i_w_dat          = i_dat_q;
    bus.pc_stall         = (state_q != RUN);
    bus.core_rst         = (state_q != RUN);
    bus.i_r_enb          = (state_q == RUN);
    bus.rd_enbl          = (state_q == RUN);
    bus.d_bram_init_done = (state_q == RUN);
    bus.done             = (state_q == RUN);
    bus.busy             = (state_q == LOAD_D) || (state_q == LOAD_I) || (state_q == FLUSH);
    bus.error            = (state_q == ERROR);
  end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: write logs are captured mid-cycle and
// compared against hand-computed address/data sequences.
module tb_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_loader_if bus ();

  mem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Status vector: ld_ready,pc_stall,core_rst,i_r_enb,rd_enbl,d_bram_init_done,busy,done,error
  logic [8:0] st;
  assign st = {bus.ld_ready, bus.pc_stall, bus.core_rst, bus.i_r_enb, bus.rd_enbl,
               bus.d_bram_init_done, bus.busy, bus.done, bus.error};

  localparam logic [8:0] ST_IDLE  = 9'b011000000;
  localparam logic [8:0] ST_LOAD  = 9'b111000100;
  localparam logic [8:0] ST_FLUSH = 9'b011000100;
  localparam logic [8:0] ST_RUN   = 9'b000111010;
  localparam logic [8:0] ST_ERROR = 9'b011000001;

  int n_chk = 0;
  int n_err = 0;

  // Write logs filled by the monitor.
  logic [9:0]  d_addr [0:1023];
  logic [31:0] d_dat  [0:1023];
  logic [9:0]  i_addr [0:1023];
  logic [31:0] i_dat  [0:1023];
  int d_n = 0;
  int i_n = 0;
  int ovl = 0;

  always @(negedge clk) begin
    if (bus.d_w_enb === 1'b1 && d_n < 1024) begin
      d_addr[d_n] = bus.d_w_addr;
      d_dat[d_n]  = bus.d_w_dat;
      d_n++;
    end
    if (bus.i_w_enb === 1'b1 && i_n < 1024) begin
      i_addr[i_n] = bus.i_w_addr;
      i_dat[i_n]  = bus.i_w_dat;
      i_n++;
    end
    if (bus.d_w_enb === 1'b1 && bus.i_w_enb === 1'b1) ovl++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.d_words = '0; bus.i_words = '0;
    bus.ld_valid = 0; bus.ld_data = '0;
    rst = 1;
    step(); step();
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL reset_status: got %b expected %b", st, ST_IDLE); end
    n_chk++; if ({bus.d_w_enb, bus.i_w_enb} !== 2'b00) begin n_err++; $display("FAIL reset_wenb: got %b expected 00", {bus.d_w_enb, bus.i_w_enb}); end
    n_chk++; if ({bus.d_w_addr, bus.i_w_addr, bus.d_w_dat, bus.i_w_dat} !== 84'h0) begin n_err++; $display("FAIL reset_addr_dat: got %h expected 0", {bus.d_w_addr, bus.i_w_addr, bus.d_w_dat, bus.i_w_dat}); end
    rst = 0;
    step();
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL idle_status: got %b expected %b", st, ST_IDLE); end
  endtask

  task automatic test_full_load();
    int db = d_n; int ib = i_n; int ob = ovl;
    bus.start = 1; bus.d_words = 9'd3; bus.i_words = 9'd7; bus.ld_valid = 1;
    for (int k = 0; k <= 11; k++) begin
      bus.ld_data = 32'hA000_0000 | k;
      step();
      bus.start = 0;
      if (k == 0) begin n_chk++; if (st !== ST_LOAD) begin n_err++; $display("FAIL full_load_d: got %b expected %b", st, ST_LOAD); end end
      if (k == 10) begin n_chk++; if (st !== ST_FLUSH) begin n_err++; $display("FAIL full_flush: got %b expected %b", st, ST_FLUSH); end end
      if (k == 11) begin n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL full_run_cycle12: got %b expected %b", st, ST_RUN); end end
    end
    bus.ld_valid = 0;
    n_chk++; if (d_n - db !== 3) begin n_err++; $display("FAIL full_d_count: got %0d expected 3", d_n - db); end
    for (int j = 0; j < 3 && j < d_n - db; j++) begin
      n_chk++;
      if (d_addr[db+j] !== 10'(j*4) || d_dat[db+j] !== (32'hA000_0000 | (j+1))) begin
        n_err++; $display("FAIL full_d_write%0d: got %h/%h expected %h/%h", j, d_addr[db+j], d_dat[db+j], 10'(j*4), 32'hA000_0000 | (j+1));
      end
    end
    n_chk++; if (i_n - ib !== 7) begin n_err++; $display("FAIL full_i_count: got %0d expected 7", i_n - ib); end
    for (int j = 0; j < 7 && j < i_n - ib; j++) begin
      n_chk++;
      if (i_addr[ib+j] !== 10'(j*4) || i_dat[ib+j] !== (32'hA000_0000 | (j+4))) begin
        n_err++; $display("FAIL full_i_write%0d: got %h/%h expected %h/%h", j, i_addr[ib+j], i_dat[ib+j], 10'(j*4), 32'hA000_0000 | (j+4));
      end
    end
    n_chk++; if (ovl - ob !== 0) begin n_err++; $display("FAIL full_overlap: got %0d expected 0", ovl - ob); end
    // start is ignored in RUN
    bus.start = 1; step(); step(); bus.start = 0;
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL run_holds: got %b expected %b", st, ST_RUN); end
    bus.abort = 1; step(); bus.abort = 0;
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL run_abort: got %b expected %b", st, ST_IDLE); end
  endtask

  task automatic test_no_data();
    int db = d_n; int ib = i_n;
    bus.start = 1; bus.d_words = 9'd0; bus.i_words = 9'd2; bus.ld_valid = 1;
    for (int k = 0; k <= 3; k++) begin
      bus.ld_data = 32'hF000_0000 | k;
      step();
      bus.start = 0;
    end
    bus.ld_valid = 0;
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL nodata_run: got %b expected %b", st, ST_RUN); end
    n_chk++; if (d_n - db !== 0) begin n_err++; $display("FAIL nodata_d_count: got %0d expected 0", d_n - db); end
    n_chk++; if (i_n - ib !== 2) begin n_err++; $display("FAIL nodata_i_count: got %0d expected 2", i_n - ib); end
    for (int j = 0; j < 2 && j < i_n - ib; j++) begin
      n_chk++;
      if (i_addr[ib+j] !== 10'(j*4) || i_dat[ib+j] !== (32'hF000_0000 | (j+1))) begin
        n_err++; $display("FAIL nodata_i_write%0d: got %h/%h expected %h/%h", j, i_addr[ib+j], i_dat[ib+j], 10'(j*4), 32'hF000_0000 | (j+1));
      end
    end
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic test_valid_toggle();
    int db = d_n; int ib = i_n;
    logic vpat [0:6];
    vpat[0] = 1; vpat[1] = 1; vpat[2] = 0; vpat[3] = 1; vpat[4] = 0; vpat[5] = 1; vpat[6] = 0;
    bus.start = 1; bus.d_words = 9'd0; bus.i_words = 9'd3;
    for (int k = 0; k <= 6; k++) begin
      bus.ld_valid = vpat[k];
      bus.ld_data  = 32'hE000_0000 | k;
      step();
      bus.start = 0;
      if (k == 4) begin n_chk++; if (st !== ST_LOAD) begin n_err++; $display("FAIL toggle_stall: got %b expected %b", st, ST_LOAD); end end
    end
    bus.ld_valid = 0;
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL toggle_run: got %b expected %b", st, ST_RUN); end
    n_chk++; if (i_n - ib !== 3 || d_n - db !== 0) begin n_err++; $display("FAIL toggle_counts: got i=%0d d=%0d expected i=3 d=0", i_n - ib, d_n - db); end
    for (int j = 0; j < 3 && j < i_n - ib; j++) begin
      n_chk++;
      if (i_addr[ib+j] !== 10'(j*4) || i_dat[ib+j] !== (32'hE000_0000 | (2*j+1))) begin
        n_err++; $display("FAIL toggle_i_write%0d: got %h/%h expected %h/%h", j, i_addr[ib+j], i_dat[ib+j], 10'(j*4), 32'hE000_0000 | (2*j+1));
      end
    end
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic test_zero_words();
    int db = d_n; int ib = i_n;
    bus.start = 1; bus.d_words = 9'd0; bus.i_words = 9'd0; bus.ld_valid = 1;
    step(); bus.start = 0;
    n_chk++; if (st !== ST_FLUSH) begin n_err++; $display("FAIL zero_flush: got %b expected %b", st, ST_FLUSH); end
    step();
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL zero_run: got %b expected %b", st, ST_RUN); end
    step(); bus.ld_valid = 0;
    n_chk++; if (d_n - db !== 0 || i_n - ib !== 0) begin n_err++; $display("FAIL zero_writes: got d=%0d i=%0d expected 0 0", d_n - db, i_n - ib); end
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic test_max_index();
    int db = d_n; int ib = i_n;
    bus.start = 1; bus.d_words = 9'd256; bus.i_words = 9'd0; bus.ld_valid = 1;
    for (int k = 0; k <= 257; k++) begin
      bus.ld_data = 32'hB000_0000 | k;
      step();
      bus.start = 0;
      if (k == 256) begin n_chk++; if (st !== ST_FLUSH) begin n_err++; $display("FAIL max_flush: got %b expected %b", st, ST_FLUSH); end end
    end
    bus.ld_valid = 0;
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL max_run: got %b expected %b", st, ST_RUN); end
    n_chk++; if (d_n - db !== 256 || i_n - ib !== 0) begin n_err++; $display("FAIL max_counts: got d=%0d i=%0d expected 256 0", d_n - db, i_n - ib); end
    if (d_n - db >= 256) begin
      n_chk++; if (d_addr[db] !== 10'h000 || d_dat[db] !== 32'hB000_0001) begin n_err++; $display("FAIL max_first: got %h/%h expected 000/b0000001", d_addr[db], d_dat[db]); end
      n_chk++; if (d_addr[db+255] !== 10'h3FC || d_dat[db+255] !== 32'hB000_0100) begin n_err++; $display("FAIL max_last: got %h/%h expected 3fc/b0000100", d_addr[db+255], d_dat[db+255]); end
    end
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic test_error();
    int db = d_n; int ib = i_n;
    bus.start = 1; bus.d_words = 9'd1; bus.i_words = 9'd257; bus.ld_valid = 1;
    step();
    n_chk++; if (st !== ST_ERROR) begin n_err++; $display("FAIL err_enter: got %b expected %b", st, ST_ERROR); end
    step(); step(); step();
    bus.start = 0; bus.ld_valid = 0;
    n_chk++; if (st !== ST_ERROR) begin n_err++; $display("FAIL err_hold: got %b expected %b", st, ST_ERROR); end
    n_chk++; if (d_n - db !== 0 || i_n - ib !== 0) begin n_err++; $display("FAIL err_writes: got d=%0d i=%0d expected 0 0", d_n - db, i_n - ib); end
    bus.abort = 1; step(); bus.abort = 0;
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL err_abort: got %b expected %b", st, ST_IDLE); end
  endtask

  task automatic test_rst_mid_load();
    int db;
    bus.start = 1; bus.d_words = 9'd3; bus.i_words = 9'd1; bus.ld_valid = 1;
    for (int k = 0; k <= 2; k++) begin
      bus.ld_data = 32'hC000_0000 | k;
      step();
      bus.start = 0;
    end
    rst = 1; bus.ld_data = 32'hC000_0003;
    step();
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL rstmid_status: got %b expected %b", st, ST_IDLE); end
    n_chk++; if ({bus.d_w_enb, bus.i_w_enb} !== 2'b00) begin n_err++; $display("FAIL rstmid_wenb: got %b expected 00", {bus.d_w_enb, bus.i_w_enb}); end
    n_chk++; if ({bus.d_w_addr, bus.i_w_addr, bus.d_w_dat, bus.i_w_dat} !== 84'h0) begin n_err++; $display("FAIL rstmid_addr_dat: got %h expected 0", {bus.d_w_addr, bus.i_w_addr, bus.d_w_dat, bus.i_w_dat}); end
    rst = 0; bus.ld_valid = 0;
    step();
    db = d_n;
    bus.start = 1; bus.d_words = 9'd1; bus.i_words = 9'd0; bus.ld_valid = 1;
    for (int k = 0; k <= 2; k++) begin
      bus.ld_data = 32'h5000_0000 | k;
      step();
      bus.start = 0;
    end
    bus.ld_valid = 0;
    n_chk++; if (st !== ST_RUN) begin n_err++; $display("FAIL rstmid_rerun: got %b expected %b", st, ST_RUN); end
    n_chk++; if (d_n - db !== 1) begin n_err++; $display("FAIL rstmid_recount: got %0d expected 1", d_n - db); end
    if (d_n - db >= 1) begin
      n_chk++; if (d_addr[db] !== 10'h000 || d_dat[db] !== 32'h5000_0001) begin n_err++; $display("FAIL rstmid_reload: got %h/%h expected 000/50000001", d_addr[db], d_dat[db]); end
    end
    bus.abort = 1; step(); bus.abort = 0;
  endtask

  task automatic test_abort();
    int db = d_n;
    bus.start = 1; bus.d_words = 9'd3; bus.i_words = 9'd1; bus.ld_valid = 1;
    bus.ld_data = 32'hD000_0000;
    step(); bus.start = 0;
    bus.ld_data = 32'hD000_0001;
    step();
    bus.abort = 1; bus.ld_data = 32'hD000_0002;
    step();
    n_chk++; if (st !== ST_IDLE) begin n_err++; $display("FAIL abort_idle: got %b expected %b", st, ST_IDLE); end
    n_chk++; if (bus.d_w_enb !== 1'b0) begin n_err++; $display("FAIL abort_no_write: got %b expected 0", bus.d_w_enb); end
    bus.abort = 0; bus.ld_valid = 0;
    step();
    n_chk++; if (bus.core_rst !== 1'b1 || st !== ST_IDLE) begin n_err++; $display("FAIL abort_core_rst: got %b/%b expected 1/%b", bus.core_rst, st, ST_IDLE); end
    n_chk++; if (d_n - db !== 1) begin n_err++; $display("FAIL abort_d_count: got %0d expected 1", d_n - db); end
    if (d_n - db >= 1) begin
      n_chk++; if (d_addr[db] !== 10'h000 || d_dat[db] !== 32'hD000_0001) begin n_err++; $display("FAIL abort_d_write: got %h/%h expected 000/d0000001", d_addr[db], d_dat[db]); end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_no_data();
    test_valid_toggle();
    test_zero_words();
    test_max_index();
    test_error();
    test_rst_mid_load();
    test_abort();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
